// File: rtl/hazard_unit_pkg.sv
// Shared constants and compare helpers for the hazard unit.
// Forward-select encodings, divide FSM state codes, register-match functions.
package hazard_unit_pkg;

    localparam logic [1:0] FWD_REG = 2'b00;
    localparam logic [1:0] FWD_W   = 2'b01;
    localparam logic [1:0] FWD_M   = 2'b10;

    localparam logic [1:0] DIV_IDLE = 2'b00;
    localparam logic [1:0] DIV_BUSY = 2'b01;
    localparam logic [1:0] DIV_DONE = 2'b10;

    // $0 is hardwired, so it never creates a dependency.
    function automatic logic reg_match(input logic [4:0] a, input logic [4:0] b);
        return (a != 5'd0) && (a == b);
    endfunction

    function automatic logic [1:0] fwd_sel(input logic [4:0] src,
                                           input logic [4:0] wr_m, input logic we_m,
                                           input logic [4:0] wr_w, input logic we_w);
        if (we_m && reg_match(src, wr_m)) return FWD_M;
        if (we_w && reg_match(src, wr_w)) return FWD_W;
        return FWD_REG;
    endfunction

endpackage

// File: rtl/hazard_unit_if.sv
// Pipeline control bus between the decoder/datapath (master) and the hazard unit (slave).
// Carries per-stage register indices and control bits in, stall/flush/forward selects out.
interface hazard_unit_if;
    logic       flush_all;
    logic [4:0] rsD, rtD, rsE, rtE;
    logic [4:0] writeregE, writeregM, writeregW;
    logic       regwriteE, regwriteM, regwriteW;
    logic       memtoRegE, memtoRegM;
    logic       branchD, jrD, divE;
    logic       forwardAD, forwardBD;
    logic [1:0] forwardAE, forwardBE;
    logic       stallF, stallD, stallE, flushE;
    logic       div_busy, div_doneE;

    modport master (
        output flush_all, rsD, rtD, rsE, rtE, writeregE, writeregM, writeregW,
               regwriteE, regwriteM, regwriteW, memtoRegE, memtoRegM, branchD, jrD, divE,
        input  forwardAD, forwardBD, forwardAE, forwardBE, stallF, stallD, stallE, flushE,
               div_busy, div_doneE
    );

    modport slave (
        input  flush_all, rsD, rtD, rsE, rtE, writeregE, writeregM, writeregW,
               regwriteE, regwriteM, regwriteW, memtoRegE, memtoRegM, branchD, jrD, divE,
        output forwardAD, forwardBD, forwardAE, forwardBE, stallF, stallD, stallE, flushE,
               div_busy, div_doneE
    );
endinterface

// File: rtl/hazard_unit_div_stall_fsm.sv
// Multi-cycle divide stall FSM: holds F/D/E for DIV_CYCLES+1 cycles, then pulses done.
// flush_all or rst return it to IDLE next cycle with no done pulse.
module hazard_unit_div_stall_fsm
    import hazard_unit_pkg::*;
#(
    parameter int DIV_CYCLES = 32
) (
    input  logic i_clk,
    input  logic i_rst,
    input  logic i_flush_all,
    input  logic i_divE,
    output logic o_div_stall,
    output logic o_div_busy,
    output logic o_div_doneE
);

    localparam logic [5:0] CNT_LOAD = 6'(DIV_CYCLES - 1);

    logic [1:0] r_state;
    logic [5:0] r_count;

    always_ff @(posedge i_clk) begin
        if (i_rst || i_flush_all) begin
            r_state <= DIV_IDLE;
            r_count <= 6'd0;
        end else begin
            case (r_state)
                DIV_IDLE: begin
                    if (i_divE) begin
                        r_state <= DIV_BUSY;
                        r_count <= CNT_LOAD;
                    end
                end
                DIV_BUSY: begin
                    if (r_count == 6'd0) r_state <= DIV_DONE;
                    else                 r_count <= r_count - 6'd1;
                end
                default: r_state <= DIV_IDLE;
            endcase
        end
    end

    // DONE releases E unconditionally; a still-high divE is the next div, seen in IDLE.
    assign o_div_stall = ((r_state == DIV_IDLE) && i_divE) || (r_state == DIV_BUSY);
    assign o_div_busy  = (r_state != DIV_IDLE);
    assign o_div_doneE = (r_state == DIV_DONE) && !i_flush_all;

endmodule

// File: rtl/hazard_unit.sv
// Hazard unit: forwarding selects, load-use/branch stalls and divide stall merge.
// Combinational outputs except the divide FSM state held in the sub-module.
module hazard_unit
    import hazard_unit_pkg::*;
#(
    parameter int DIV_CYCLES = 32
) (
    input  logic          clk,
    input  logic          rst,
    hazard_unit_if.slave  hz
);

    logic w_lwstall;
    logic w_branchstall;
    logic w_div_stall;
    logic w_hit_rs;
    logic w_hit_rt;

    hazard_unit_div_stall_fsm #(.DIV_CYCLES(DIV_CYCLES)) u_div_fsm (
        .i_clk       (clk),
        .i_rst       (rst),
        .i_flush_all (hz.flush_all),
        .i_divE      (hz.divE),
        .o_div_stall (w_div_stall),
        .o_div_busy  (hz.div_busy),
        .o_div_doneE (hz.div_doneE)
    );

    assign hz.forwardAE = fwd_sel(hz.rsE, hz.writeregM, hz.regwriteM, hz.writeregW, hz.regwriteW);
    assign hz.forwardBE = fwd_sel(hz.rtE, hz.writeregM, hz.regwriteM, hz.writeregW, hz.regwriteW);
    assign hz.forwardAD = hz.regwriteM && reg_match(hz.rsD, hz.writeregM);
    assign hz.forwardBD = hz.regwriteM && reg_match(hz.rtD, hz.writeregM);

    assign w_lwstall = hz.memtoRegE && hz.regwriteE &&
                       (reg_match(hz.rsD, hz.writeregE) || reg_match(hz.rtD, hz.writeregE));

    // Comparator in D cannot take an operand still in the E ALU or a load still in M.
    assign w_hit_rs = (hz.regwriteE && reg_match(hz.rsD, hz.writeregE)) ||
                      (hz.memtoRegM && reg_match(hz.rsD, hz.writeregM));
    assign w_hit_rt = (hz.regwriteE && reg_match(hz.rtD, hz.writeregE)) ||
                      (hz.memtoRegM && reg_match(hz.rtD, hz.writeregM));
    assign w_branchstall = (hz.branchD && (w_hit_rs || w_hit_rt)) || (hz.jrD && w_hit_rs);

    assign hz.stallF = !hz.flush_all && (w_lwstall || w_branchstall || w_div_stall);
    assign hz.stallD = hz.stallF;
    assign hz.stallE = !hz.flush_all && w_div_stall;
    assign hz.flushE = hz.flush_all || ((w_lwstall || w_branchstall) && !w_div_stall);

endmodule

// File: tb/tb_hazard_unit.sv
// Directed self-checking bench for hazard_unit with DIV_CYCLES=4.
module tb_hazard_unit;
    import hazard_unit_pkg::*;

    logic clk = 1'b0;
    logic rst;
    int   n_tests = 0;
    int   n_fail  = 0;

    hazard_unit_if hif ();

    hazard_unit #(.DIV_CYCLES(4)) dut (
        .clk (clk),
        .rst (rst),
        .hz  (hif.slave)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_tests++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    task automatic clear_inputs();
        hif.flush_all = 0; hif.rsD = 0; hif.rtD = 0; hif.rsE = 0; hif.rtE = 0;
        hif.writeregE = 0; hif.writeregM = 0; hif.writeregW = 0;
        hif.regwriteE = 0; hif.regwriteM = 0; hif.regwriteW = 0;
        hif.memtoRegE = 0; hif.memtoRegM = 0; hif.branchD = 0; hif.jrD = 0; hif.divE = 0;
    endtask

    // Inputs are driven just after a falling edge, outputs sampled 1ns later.
    task automatic step();
        @(negedge clk);
    endtask

    function automatic logic [11:0] all_out();
        return {hif.forwardAD, hif.forwardBD, hif.forwardAE, hif.forwardBE,
                hif.stallF, hif.stallD, hif.stallE, hif.flushE, hif.div_busy, hif.div_doneE};
    endfunction

    int first_pulse, last_pulse, n_pulse;

    initial begin
        clear_inputs();
        rst = 1;
        step(); step();
        rst = 0;
        step(); #1;
        check("reset_all_out", 32'(all_out()), 32'h0);

        // Forwarding to E: M priority over W
        step(); clear_inputs();
        hif.regwriteM = 1; hif.writeregM = 2; hif.rsE = 2; #1;
        check("fwdAE_M", 32'(hif.forwardAE), 32'(2'b10));
        step(); clear_inputs();
        hif.regwriteW = 1; hif.writeregW = 2; hif.rsE = 2; #1;
        check("fwdAE_W", 32'(hif.forwardAE), 32'(2'b01));
        step(); clear_inputs();
        hif.regwriteM = 1; hif.writeregM = 7; hif.regwriteW = 1; hif.writeregW = 7;
        hif.rtE = 7; hif.rsE = 6; #1;
        check("fwdBE_Mprio", 32'(hif.forwardBE), 32'(2'b10));
        check("fwdAE_nomatch", 32'(hif.forwardAE), 32'(2'b00));

        // Load-use stall for exactly one cycle
        step(); clear_inputs();
        hif.memtoRegE = 1; hif.regwriteE = 1; hif.writeregE = 3; hif.rtD = 3; #1;
        check("lw_stall_bits", 32'({hif.stallF, hif.stallD, hif.stallE, hif.flushE}), 32'b1101);
        step(); clear_inputs();
        hif.memtoRegM = 1; hif.regwriteM = 1; hif.writeregM = 3; hif.rtD = 3; hif.rtE = 3; #1;
        check("lw_after_stall", 32'({hif.stallF, hif.stallD, hif.flushE}), 32'b000);
        check("lw_after_fwdBE", 32'(hif.forwardBE), 32'(2'b10));

        // Branch operand in E: stall, then forward from M
        step(); clear_inputs();
        hif.branchD = 1; hif.rsD = 4; hif.regwriteE = 1; hif.writeregE = 4; #1;
        check("br_stall", 32'({hif.stallF, hif.stallD, hif.stallE, hif.flushE}), 32'b1101);
        step(); clear_inputs();
        hif.branchD = 1; hif.rsD = 4; hif.regwriteM = 1; hif.writeregM = 4; #1;
        check("br_fwdAD", 32'({hif.forwardAD, hif.forwardBD, hif.stallD}), 32'b100);
        // jr ignores rt, but sees a load in M on rs
        step(); clear_inputs();
        hif.jrD = 1; hif.rtD = 5; hif.regwriteE = 1; hif.writeregE = 5; #1;
        check("jr_rt_ignored", 32'(hif.stallD), 32'h0);
        step(); clear_inputs();
        hif.jrD = 1; hif.rsD = 9; hif.memtoRegM = 1; hif.regwriteM = 1; hif.writeregM = 9; #1;
        check("jr_rs_loadM", 32'({hif.stallD, hif.flushE}), 32'b11);

        // $0 never matches
        step(); clear_inputs();
        hif.regwriteM = 1; hif.writeregM = 0; hif.rsE = 0; #1;
        check("zero_reg_fwd", 32'(hif.forwardAE), 32'(2'b00));

        // Back-to-back divides: 5 stall cycles, pulse on 6th, repeat
        step(); clear_inputs();
        first_pulse = -1; last_pulse = -1; n_pulse = 0;
        for (int k = 0; k < 12; k++) begin
            if (k > 0) step();
            hif.divE = 1;
            hif.memtoRegE = 0;
            if (k == 2) begin
                hif.memtoRegE = 1; hif.regwriteE = 1; hif.writeregE = 8; hif.rsD = 8;
            end
            #1;
            check($sformatf("div_stallE_%0d", k), 32'(hif.stallE), 32'((k % 6) < 5));
            check($sformatf("div_done_%0d", k), 32'(hif.div_doneE), 32'((k % 6) == 5));
            if (k == 2) check("div_no_flushE", 32'({hif.stallD, hif.flushE}), 32'b10);
            if (hif.div_doneE) begin
                if (first_pulse < 0) first_pulse = k;
                last_pulse = k;
                n_pulse++;
            end
            hif.regwriteE = 0; hif.writeregE = 0; hif.rsD = 0;
        end
        check("div_pulse_count", 32'(n_pulse), 32'd2);
        check("div_pulse_gap", 32'(last_pulse - first_pulse), 32'd6);

        // flush_all in BUSY with count=2
        step(); clear_inputs(); #1;
        check("div_idle_after", 32'(hif.div_busy), 32'h0);
        step(); hif.divE = 1;
        step();
        step(); hif.flush_all = 1; #1;
        check("flush_bits", 32'({hif.stallF, hif.stallD, hif.stallE, hif.flushE}), 32'b0001);
        step(); clear_inputs(); #1;
        check("flush_idle", 32'({hif.div_busy, hif.div_doneE, hif.stallE}), 32'b000);

        // flush_all during DONE suppresses the pulse
        step(); hif.divE = 1;
        for (int k = 0; k < 5; k++) step();
        hif.flush_all = 1; #1;
        check("flush_in_done", 32'(hif.div_doneE), 32'h0);
        step(); clear_inputs(); #1;
        check("flush_done_idle", 32'(hif.div_busy), 32'h0);

        // rst mid-BUSY
        step(); hif.divE = 1;
        step(); step(); #1;
        check("busy_before_rst", 32'(hif.div_busy), 32'h1);
        rst = 1; hif.divE = 0;
        step(); rst = 0; #1;
        check("rst_mid_busy", 32'(all_out()), 32'h0);
        step(); #1;
        check("rst_no_done", 32'(hif.div_doneE), 32'h0);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

    initial begin
        #100000;
        $display("FAIL timeout: simulation did not finish, expected finish");
        $fatal(1);
    end

endmodule
